// File: rtl/conv_pool_sequencer.sv
// Control sequencer for the convolution/max-pool engine: steers tagged beats into the
// weight/input chains, fires the MAC per window and max-pools POOL_WIN results.
// Optional pooled-output counter enabled by CONV_POOL_PERF_CNT_EN.
module conv_pool_sequencer #(
  parameter int unsigned DW       = 6,
  parameter int unsigned TAPS     = 4,
  parameter int unsigned POOL_WIN = 4,
  parameter int unsigned RW       = 2*DW + $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_is_weight,
  output logic [DW-1:0] dp_data,
  output logic          dp_shift_w,
  output logic          dp_shift_x,
  output logic          dp_mac_en,
  input  logic [RW-1:0] dp_result,
  output logic          pool_valid,
  output logic [RW-1:0] pool_result,
  output logic          busy,
  output logic          weights_loaded,
  output logic [15:0]   pool_count
);

  localparam int unsigned TCW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned WCW = (POOL_WIN > 1) ? $clog2(POOL_WIN) : 1;
  localparam logic [TCW-1:0] TAP_LAST = TCW'(TAPS - 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(POOL_WIN - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, MAC, CAPTURE} state_e;

  state_e          state_q, state_d;
  logic [TCW-1:0]  tap_q, tap_d;
  logic [WCW-1:0]  win_q, win_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   pr_q, pr_d;
  logic            wl_q, wl_d;
  logic            pv_q, pv_d;
  logic            ready_c;
  logic            xfer_c;
  logic [RW-1:0]   new_max_c;

  // Acceptance depends only on state and the beat's tag, never on in_valid
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      IDLE:    ready_c = in_is_weight | wl_q;
      LOAD_W:  ready_c = in_is_weight;
      LOAD_X:  ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  assign in_ready       = rst_n & ready_c;
  assign xfer_c         = in_valid & in_ready;
  assign dp_data        = in_data;
  assign dp_shift_w     = xfer_c & in_is_weight;
  assign dp_shift_x     = xfer_c & ~in_is_weight;
  assign dp_mac_en      = rst_n & (state_q == MAC);
  assign busy           = (state_q != IDLE);
  assign weights_loaded = wl_q;
  assign pool_valid     = pv_q;
  assign pool_result    = pr_q;

  // First window of a group seeds the max; ties keep the running value
  assign new_max_c = ((win_q == '0) || (dp_result > acc_q)) ? dp_result : acc_q;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    win_d   = win_q;
    acc_d   = acc_q;
    wl_d    = wl_q;
    pr_d    = pr_q;
    pv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          if (in_is_weight) begin
            if (TAPS == 1) begin
              wl_d  = 1'b1;
              tap_d = '0;
            end else begin
              wl_d    = 1'b0;
              tap_d   = TCW'(1);
              state_d = LOAD_W;
            end
          end else begin
            if (TAPS == 1) begin
              tap_d   = '0;
              state_d = MAC;
            end else begin
              tap_d   = TCW'(1);
              state_d = LOAD_X;
            end
          end
        end
      end
      LOAD_W: begin
        if (xfer_c) begin
          if (tap_q == TAP_LAST) begin
            wl_d    = 1'b1;
            tap_d   = '0;
            state_d = IDLE;
          end else begin
            tap_d = tap_q + TCW'(1);
          end
        end
      end
      LOAD_X: begin
        if (xfer_c) begin
          if (in_is_weight) begin
            // A weight beat mid-window abandons both the window and the pool group
            acc_d = '0;
            win_d = '0;
            if (TAPS == 1) begin
              wl_d    = 1'b1;
              tap_d   = '0;
              state_d = IDLE;
            end else begin
              wl_d    = 1'b0;
              tap_d   = TCW'(1);
              state_d = LOAD_W;
            end
          end else if (tap_q == TAP_LAST) begin
            tap_d   = '0;
            state_d = MAC;
          end else begin
            tap_d = tap_q + TCW'(1);
          end
        end
      end
      MAC: state_d = CAPTURE;
      CAPTURE: begin
        acc_d = new_max_c;
        if (win_q == WIN_LAST) begin
          pr_d  = new_max_c;
          pv_d  = 1'b1;
          win_d = '0;
        end else begin
          win_d = win_q + WCW'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      pr_q    <= '0;
      wl_q    <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      pr_q    <= pr_d;
      wl_q    <= wl_d;
      pv_q    <= pv_d;
    end
  end

`ifdef CONV_POOL_PERF_CNT_EN
  logic [15:0] pool_cnt_q;

  // Saturating count of emitted pooled results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pool_cnt_q <= '0;
    end else if (pv_q && (pool_cnt_q != 16'hFFFF)) begin
      pool_cnt_q <= pool_cnt_q + 16'd1;
    end
  end

  assign pool_count = pool_cnt_q;
`else
  assign pool_count = 16'h0000;
`endif

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// Directed bench for conv_pool_sequencer: two instances (POOL_WIN=1 and 4) share stimulus
// and a behavioural dot-product datapath model.
module tb_conv_pool_sequencer;

  localparam int unsigned DW = 6;
  localparam int unsigned RW = 14;
`ifdef CONV_POOL_PERF_CNT_EN
  localparam int EXP_CNT3 = 3;
`else
  localparam int EXP_CNT3 = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, in_is_weight;
  logic [DW-1:0] in_data;
  logic [RW-1:0] dp_result;

  logic          in_ready1, sw1, sx1, mac1, pv1, busy1, wl1;
  logic [DW-1:0] dp_data1;
  logic [RW-1:0] pr1;
  logic [15:0]   cnt1;
  logic          in_ready4, sw4, sx4, mac4, pv4, busy4, wl4;
  logic [DW-1:0] dp_data4;
  logic [RW-1:0] pr4;
  logic [15:0]   cnt4;

  int checks = 0;
  int errors = 0;
  int nsw = 0, nsx = 0, nmac = 0, npv4 = 0;

  always #5 clk = ~clk;

  conv_pool_sequencer #(.DW(6), .TAPS(4), .POOL_WIN(1)) u_pw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_is_weight(in_is_weight), .dp_data(dp_data1), .dp_shift_w(sw1), .dp_shift_x(sx1),
    .dp_mac_en(mac1), .dp_result(dp_result), .pool_valid(pv1), .pool_result(pr1),
    .busy(busy1), .weights_loaded(wl1), .pool_count(cnt1));

  conv_pool_sequencer #(.DW(6), .TAPS(4), .POOL_WIN(4)) u_pw4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_is_weight(in_is_weight), .dp_data(dp_data4), .dp_shift_w(sw4), .dp_shift_x(sx4),
    .dp_mac_en(mac4), .dp_result(dp_result), .pool_valid(pv4), .pool_result(pr4),
    .busy(busy4), .weights_loaded(wl4), .pool_count(cnt4));

  // Datapath model: two 4-deep shift chains and a registered dot product
  logic [DW-1:0] wch [4];
  logic [DW-1:0] xch [4];

  function automatic logic [RW-1:0] dot();
    logic [RW-1:0] s = '0;
    for (int i = 0; i < 4; i++) s = s + RW'(wch[i]) * RW'(xch[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wch[i] <= '0;
        xch[i] <= '0;
      end
      dp_result <= '0;
    end else begin
      if (sw1) begin
        for (int i = 0; i < 3; i++) wch[i+1] <= wch[i];
        wch[0] <= dp_data1;
      end
      if (sx1) begin
        for (int i = 0; i < 3; i++) xch[i+1] <= xch[i];
        xch[0] <= dp_data1;
      end
      if (mac1) dp_result <= dot();
    end
  end

  always @(posedge clk) begin
    if (sw1) nsw <= nsw + 1;
    if (sx1) nsx <= nsx + 1;
    if (mac1) nmac <= nmac + 1;
    if (pv4) npv4 <= npv4 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_is_weight = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic w);
    int n = 0;
    in_data = d; in_is_weight = w; in_valid = 1'b1;
    #1;
    while (!in_ready1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL beat_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_weights(input logic [DW-1:0] v);
    for (int i = 0; i < 4; i++) send_beat(v, 1'b1);
  endtask

  // Returns at the cycle where pool_valid for this window is expected
  task automatic send_window(input logic [DW-1:0] v);
    for (int i = 0; i < 4; i++) send_beat(v, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready_x: got %0b expected 0", in_ready1); end
    checks++; if ({busy1, wl1, pv1, mac1, sw1, sx1} !== 6'b0) begin errors++; $display("FAIL rst_ctrl1: got %b expected 000000", {busy1, wl1, pv1, mac1, sw1, sx1}); end
    checks++; if ({in_ready4, busy4, wl4, pv4, mac4, sw4, sx4} !== 7'b0) begin errors++; $display("FAIL rst_ctrl4: got %b expected 0000000", {in_ready4, busy4, wl4, pv4, mac4, sw4, sx4}); end
    checks++; if (pr1 !== '0 || pr4 !== '0) begin errors++; $display("FAIL rst_result: got %0d/%0d expected 0/0", pr1, pr4); end
    checks++; if (cnt1 !== 16'h0 || cnt4 !== 16'h0) begin errors++; $display("FAIL rst_count: got %0d/%0d expected 0/0", cnt1, cnt4); end
    in_is_weight = 1'b1; in_data = 6'h2A;
    #1;
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL idle_ready_w: got %0b expected 1", in_ready1); end
    checks++; if (dp_data1 !== 6'h2A || dp_data4 !== 6'h2A) begin errors++; $display("FAIL dp_data: got %0h/%0h expected 2a", dp_data1, dp_data4); end
  endtask

  task automatic test_basic();
    int m0;
    do_reset();
    load_weights(6'd1);
    checks++; if (wl1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL basic_wl: got wl=%0b busy=%0b expected 1/0", wl1, busy1); end
    m0 = nmac;
    for (int i = 1; i <= 4; i++) send_beat(6'(i), 1'b0);
    checks++; if (mac1 !== 1'b1) begin errors++; $display("FAIL basic_mac_t1: got %0b expected 1", mac1); end
    @(posedge clk); #1;
    checks++; if (mac1 !== 1'b0 || in_ready1 !== 1'b0) begin errors++; $display("FAIL basic_capture: got mac=%0b ready=%0b expected 0/0", mac1, in_ready1); end
    @(posedge clk); #1;
    checks++; if (pv1 !== 1'b1 || pr1 !== 14'd10) begin errors++; $display("FAIL basic_pool: got pv=%0b res=%0d expected 1/10", pv1, pr1); end
    checks++; if (pv4 !== 1'b0) begin errors++; $display("FAIL basic_pv4: got %0b expected 0", pv4); end
    @(posedge clk); #1;
    checks++; if (pv1 !== 1'b0 || pr1 !== 14'd10) begin errors++; $display("FAIL basic_hold: got pv=%0b res=%0d expected 0/10", pv1, pr1); end
    checks++; if (nmac - m0 !== 1) begin errors++; $display("FAIL basic_mac_count: got %0d expected 1", nmac - m0); end
  endtask

  task automatic test_pool4();
    logic [DW-1:0] vals [4];
    int p;
    vals = '{6'd1, 6'd63, 6'd2, 6'd0};
    do_reset();
    load_weights(6'd63);
    p = npv4;
    for (int i = 0; i < 4; i++) begin
      send_window(vals[i]);
      if (i < 3) begin
        checks++; if (pv4 !== 1'b0 || npv4 - p !== 0) begin errors++; $display("FAIL pool4_early_%0d: got pv=%0b n=%0d expected 0/0", i, pv4, npv4 - p); end
      end else begin
        checks++; if (pv4 !== 1'b1 || pr4 !== 14'd15876) begin errors++; $display("FAIL pool4_result: got pv=%0b res=%0d expected 1/15876", pv4, pr4); end
        checks++; if (pr1 !== 14'd0) begin errors++; $display("FAIL pool1_last: got %0d expected 0", pr1); end
      end
    end
    @(posedge clk); #1;
    checks++; if (npv4 - p !== 1) begin errors++; $display("FAIL pool4_count: got %0d expected 1", npv4 - p); end
  endtask

  task automatic test_no_weights();
    int s;
    do_reset();
    s = nsx;
    in_is_weight = 1'b0; in_data = 6'd5; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (in_ready1 !== 1'b0 || sx1 !== 1'b0) begin errors++; $display("FAIL nowt_ready: got ready=%0b shx=%0b expected 0/0", in_ready1, sx1); end
    checks++; if (busy1 !== 1'b0 || nsx - s !== 0) begin errors++; $display("FAIL nowt_state: got busy=%0b shifts=%0d expected 0/0", busy1, nsx - s); end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [DW-1:0] vals [4];
    logic [RW-1:0] exp1 [4];
    int p;
    vals = '{6'd3, 6'd1, 6'd2, 6'd1};
    exp1 = '{14'd24, 14'd8, 14'd16, 14'd8};
    do_reset();
    load_weights(6'd1);
    send_window(6'd63);
    p = npv4;
    send_beat(6'd3, 1'b0);
    send_beat(6'd3, 1'b0);
    send_beat(6'd2, 1'b1);
    checks++; if (busy1 !== 1'b1 || wl1 !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%0b wl=%0b expected 1/0", busy1, wl1); end
    in_is_weight = 1'b0; #1;
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL abort_ldw_ready_x: got %0b expected 0", in_ready1); end
    for (int i = 0; i < 3; i++) send_beat(6'd2, 1'b1);
    checks++; if (wl1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL abort_reload: got wl=%0b busy=%0b expected 1/0", wl1, busy1); end
    for (int i = 0; i < 4; i++) begin
      send_window(vals[i]);
      checks++; if (pv1 !== 1'b1 || pr1 !== exp1[i]) begin errors++; $display("FAIL abort_pw1_%0d: got pv=%0b res=%0d expected 1/%0d", i, pv1, pr1, exp1[i]); end
      if (i < 3) begin
        checks++; if (pv4 !== 1'b0) begin errors++; $display("FAIL abort_pw4_early_%0d: got %0b expected 0", i, pv4); end
      end else begin
        checks++; if (pv4 !== 1'b1 || pr4 !== 14'd24) begin errors++; $display("FAIL abort_pw4: got pv=%0b res=%0d expected 1/24", pv4, pr4); end
      end
    end
    checks++; if (npv4 - p !== 0) begin errors++; $display("FAIL abort_no_pulse: got %0d expected 0", npv4 - p); end
  endtask

  task automatic test_toggle();
    int w0, x0, m0;
    do_reset();
    w0 = nsw; x0 = nsx; m0 = nmac;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      in_is_weight = (i < 4);
      in_data = (i < 4) ? 6'd5 : 6'(i - 3);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    in_valid = 1'b1; in_is_weight = 1'b0;
    #1;
    checks++; if (in_ready1 !== 1'b0 || mac1 !== 1'b1) begin errors++; $display("FAIL toggle_mac: got ready=%0b mac=%0b expected 0/1", in_ready1, mac1); end
    @(posedge clk); #1;
    in_is_weight = 1'b1; #1;
    checks++; if (in_ready1 !== 1'b0 || sw1 !== 1'b0) begin errors++; $display("FAIL toggle_capture: got ready=%0b shw=%0b expected 0/0", in_ready1, sw1); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (nsw - w0 !== 4 || nsx - x0 !== 4) begin errors++; $display("FAIL toggle_shifts: got w=%0d x=%0d expected 4/4", nsw - w0, nsx - x0); end
    checks++; if (nmac - m0 !== 1 || pv1 !== 1'b1 || pr1 !== 14'd50) begin errors++; $display("FAIL toggle_result: got mac=%0d pv=%0b res=%0d expected 1/1/50", nmac - m0, pv1, pr1); end
  endtask

  task automatic test_reset_capture();
    do_reset();
    load_weights(6'd1);
    for (int i = 0; i < 3; i++) send_window(6'd2);
    @(posedge clk); #1;
    checks++; if (cnt1 !== 16'(EXP_CNT3) || cnt4 !== 16'h0) begin errors++; $display("FAIL perf_count: got %0d/%0d expected %0d/0", cnt1, cnt4, EXP_CNT3); end
    for (int i = 0; i < 4; i++) send_beat(6'd2, 1'b0);
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b1 || mac1 !== 1'b0) begin errors++; $display("FAIL rc_in_capture: got busy=%0b mac=%0b expected 1/0", busy1, mac1); end
    rst_n = 1'b0; in_valid = 1'b1; in_is_weight = 1'b1;
    #1;
    checks++; if (in_ready1 !== 1'b0 || sw1 !== 1'b0) begin errors++; $display("FAIL rc_ready_in_reset: got ready=%0b shw=%0b expected 0/0", in_ready1, sw1); end
    @(posedge clk); #1;
    checks++; if ({busy1, wl1, pv1, mac1} !== 4'b0 || pr1 !== '0) begin errors++; $display("FAIL rc_cleared1: got ctrl=%b res=%0d expected 0000/0", {busy1, wl1, pv1, mac1}, pr1); end
    checks++; if (pv4 !== 1'b0 || pr4 !== '0 || cnt1 !== 16'h0 || cnt4 !== 16'h0) begin errors++; $display("FAIL rc_cleared4: got pv=%0b res=%0d cnt=%0d/%0d expected 0/0/0/0", pv4, pr4, cnt1, cnt4); end
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (pv1 !== 1'b0 || pv4 !== 1'b0 || pr1 !== '0) begin errors++; $display("FAIL rc_no_pulse: got pv=%0b/%0b res=%0d expected 0/0/0", pv1, pv4, pr1); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_is_weight = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_pool4();
    test_no_weights();
    test_abort();
    test_toggle();
    test_reset_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
